// File: rtl/fc_ibuf_ctrl_if.sv
// Handshake bundle between the FC input-buffer sequencer and its neighbours:
// upstream obuf valid/ready, ibuf write/shift strobes and the crossbar
// address/bit-plane stream. The controller side uses the slave modport.
interface fc_ibuf_ctrl_if #(
    parameter int ADDR_W = 1,
    parameter int BIT_W  = 3
);
    logic              i_start;
    logic              i_in_valid;
    logic              o_in_ready;
    logic              o_we;
    logic              o_se;
    logic [ADDR_W-1:0] o_ibuf_addr;
    logic              o_xbar_valid;
    logic              i_xbar_ready;
    logic [BIT_W-1:0]  o_bit_idx;
    logic              o_last_bit;
    logic              o_busy;
    logic              o_done;

    // Environment side: issues start, upstream data valid and crossbar ready.
    modport master (
        output i_start, i_in_valid, i_xbar_ready,
        input  o_in_ready, o_we, o_se, o_ibuf_addr, o_xbar_valid,
               o_bit_idx, o_last_bit, o_busy, o_done
    );

    // Controller side.
    modport slave (
        input  i_start, i_in_valid, i_xbar_ready,
        output o_in_ready, o_we, o_se, o_ibuf_addr, o_xbar_valid,
               o_bit_idx, o_last_bit, o_busy, o_done
    );
endinterface

// File: rtl/fc_ibuf_ctrl.sv
// FC-layer input buffer sequencer. One pass = load FIFO_LENGTH words from
// upstream, then stream the buffer bit-serially (LSB plane first): every
// ibuf address of the current plane to the crossbar, then one ibuf shift,
// repeated for DATA_SIZE planes with no shift after the last plane.
module fc_ibuf_ctrl #(
    parameter int DATA_SIZE   = 8,
    parameter int FIFO_LENGTH = 4,
    parameter int NUM_ADDR    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fc_ibuf_ctrl_if.slave bus
);
    localparam int ADDR_W = (NUM_ADDR > 1)    ? $clog2(NUM_ADDR)    : 1;
    localparam int BIT_W  = (DATA_SIZE > 1)   ? $clog2(DATA_SIZE)   : 1;
    localparam int WR_W   = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;

    localparam logic [WR_W-1:0]   WR_LAST   = WR_W'(FIFO_LENGTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_ADDR - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [WR_W-1:0]   wr_cnt_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_q;

    logic in_fire;
    logic xbar_fire;

    assign in_fire   = (state_q == S_LOAD)   && bus.i_in_valid;
    assign xbar_fire = (state_q == S_STREAM) && bus.i_xbar_ready;

    // Pass sequencer: state plus write, address and bit-plane counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_cnt_q   <= '0;
            addr_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state_q    <= S_LOAD;
                        wr_cnt_q   <= '0;
                        addr_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        if (wr_cnt_q == WR_LAST) begin
                            wr_cnt_q <= '0;
                            state_q  <= S_STREAM;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + WR_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    // Address and plane stay put until the crossbar accepts.
                    if (xbar_fire) begin
                        if (addr_cnt_q == ADDR_LAST) begin
                            addr_cnt_q <= '0;
                            // The last plane needs no shift: the buffer is reloaded next pass.
                            state_q    <= (bit_cnt_q == BIT_LAST) ? S_DONE : S_SHIFT;
                        end else begin
                            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    state_q   <= S_STREAM;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state. Address and bit index are
    // only meaningful while a vector is offered, so they read 0 otherwise;
    // this also keeps o_last_bit low outside STREAM for single-plane builds.
    assign bus.o_in_ready   = (state_q == S_LOAD);
    assign bus.o_we         = in_fire;
    assign bus.o_se         = (state_q == S_SHIFT);
    assign bus.o_xbar_valid = (state_q == S_STREAM);
    assign bus.o_ibuf_addr  = (state_q == S_STREAM) ? addr_cnt_q : '0;
    assign bus.o_bit_idx    = (state_q == S_STREAM) ? bit_cnt_q  : '0;
    assign bus.o_last_bit   = (state_q == S_STREAM) && (bit_cnt_q == BIT_LAST);
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_done       = (state_q == S_DONE);
endmodule

// File: tb/tb_fc_ibuf_ctrl.sv
// Bench for fc_ibuf_ctrl: a default build (8 planes, 4 words, 2 addresses)
// and a single-plane, single-address build (1 plane, 3 words, 1 address)
// driven in lockstep. Each DUT is compared every cycle against a pass model
// expressed as "words left to load, handshakes completed, shift/done pending".
module tb_fc_ibuf_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fc_ibuf_ctrl_if #(.ADDR_W(1), .BIT_W(3)) bus0 ();
    fc_ibuf_ctrl_if #(.ADDR_W(1), .BIT_W(1)) bus1 ();

    fc_ibuf_ctrl #(.DATA_SIZE(8), .FIFO_LENGTH(4), .NUM_ADDR(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    fc_ibuf_ctrl #(.DATA_SIZE(1), .FIFO_LENGTH(3), .NUM_ADDR(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Pass model per DUT.
    int m_wl [2];   // words still to load in this pass
    int m_k  [2];   // crossbar handshakes completed in this pass
    int m_in [2];   // pass in progress (load or stream phase)
    int m_sh [2];   // shift cycle pending
    int m_dn [2];   // done cycle pending

    // Values sampled by the most recent step.
    int s_we0, s_se0, s_done0, s_last0, s_addr0, s_bit0;
    int tot_se1   = 0;
    int tot_done1 = 0;
    int cyc       = 0;

    logic cur_v;

    function automatic int md(input int i); return (i == 0) ? 8 : 1; endfunction
    function automatic int mn(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int mf(input int i); return (i == 0) ? 4 : 3; endfunction

    function automatic int is_load(input int i);
        return (m_in[i] != 0 && m_wl[i] > 0) ? 1 : 0;
    endfunction

    function automatic int is_stream(input int i);
        return (m_in[i] != 0 && m_wl[i] == 0 && m_sh[i] == 0 && m_k[i] < md(i) * mn(i)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wl[i] = 0; m_k[i] = 0; m_in[i] = 0; m_sh[i] = 0; m_dn[i] = 0;
        end
    endtask

    // What happens to the pass at the next rising edge, given this cycle's inputs.
    task automatic model_advance(input int i, input logic s, input logic v, input logic r);
        if (is_load(i) != 0) begin
            if (v) m_wl[i]--;
        end else if (m_sh[i] != 0) begin
            m_sh[i] = 0;
        end else if (is_stream(i) != 0) begin
            if (r) begin
                m_k[i]++;
                if (m_k[i] == md(i) * mn(i)) begin
                    m_in[i] = 0;
                    m_dn[i] = 1;
                end else if (m_k[i] % mn(i) == 0) begin
                    m_sh[i] = 1;
                end
            end
        end else if (m_dn[i] != 0) begin
            m_dn[i] = 0;
        end else if (s) begin
            m_in[i] = 1;
            m_wl[i] = mf(i);
            m_k[i]  = 0;
        end
    endtask

    task automatic check_all(input int i, input string ph);
        logic [31:0] o_rdy, o_we, o_se, o_xv, o_addr, o_bit, o_last, o_busy, o_done;
        int st, ld;
        string p;
        if (i == 0) begin
            o_rdy = 32'(bus0.o_in_ready);  o_we   = 32'(bus0.o_we);
            o_se  = 32'(bus0.o_se);        o_xv   = 32'(bus0.o_xbar_valid);
            o_addr = 32'(bus0.o_ibuf_addr); o_bit = 32'(bus0.o_bit_idx);
            o_last = 32'(bus0.o_last_bit); o_busy = 32'(bus0.o_busy);
            o_done = 32'(bus0.o_done);
        end else begin
            o_rdy = 32'(bus1.o_in_ready);  o_we   = 32'(bus1.o_we);
            o_se  = 32'(bus1.o_se);        o_xv   = 32'(bus1.o_xbar_valid);
            o_addr = 32'(bus1.o_ibuf_addr); o_bit = 32'(bus1.o_bit_idx);
            o_last = 32'(bus1.o_last_bit); o_busy = 32'(bus1.o_busy);
            o_done = 32'(bus1.o_done);
        end
        p  = $sformatf("%s dut%0d cyc%0d", ph, i, cyc);
        ld = is_load(i);
        st = is_stream(i);
        chk({p, " in_ready"}, o_rdy, 32'(ld));
        chk({p, " we"}, o_we, 32'((ld != 0) && cur_v && rst_n));
        chk({p, " se"}, o_se, 32'(m_sh[i]));
        chk({p, " xbar_valid"}, o_xv, 32'(st));
        chk({p, " addr"}, o_addr, 32'((st != 0) ? m_k[i] % mn(i) : 0));
        chk({p, " bit_idx"}, o_bit, 32'((st != 0) ? m_k[i] / mn(i) : 0));
        chk({p, " last_bit"}, o_last, 32'((st != 0) && (m_k[i] / mn(i) == md(i) - 1)));
        chk({p, " busy"}, o_busy, 32'((m_in[i] != 0) || (m_dn[i] != 0)));
        chk({p, " done"}, o_done, 32'(m_dn[i]));
        chk({p, " we_se_exclusive"}, o_we & o_se, 32'd0);
    endtask

    // One clock cycle: drive at edge+1, sample and check at edge+2, advance the model.
    task automatic step(input logic s, input logic v, input logic r, input string ph);
        bus0.i_start = s; bus0.i_in_valid = v; bus0.i_xbar_ready = r;
        bus1.i_start = s; bus1.i_in_valid = v; bus1.i_xbar_ready = r;
        cur_v = v;
        #1;
        check_all(0, ph);
        check_all(1, ph);
        s_we0   = int'(bus0.o_we);
        s_se0   = int'(bus0.o_se);
        s_done0 = int'(bus0.o_done);
        s_last0 = int'(bus0.o_last_bit);
        s_addr0 = int'(bus0.o_ibuf_addr);
        s_bit0  = int'(bus0.o_bit_idx);
        tot_se1   += int'(bus1.o_se);
        tot_done1 += int'(bus1.o_done);
        if (bus0.o_done) $display("dut0 pass complete at cycle %0d", cyc);
        if (bus1.o_done) $display("dut1 pass complete at cycle %0d", cyc);
        if (rst_n) begin
            model_advance(0, s, v, r);
            model_advance(1, s, v, r);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input string ph);
        int ok;
        ok = 0;
        for (int j = 0; j < 200; j++) begin
            if (m_in[0] == 0 && m_dn[0] == 0 && m_in[1] == 0 && m_dn[1] == 0) begin
                ok = 1;
                break;
            end
            step(1'b0, 1'b1, 1'b1, ph);
        end
        chk({ph, " reached idle"}, 32'(ok), 32'd1);
    endtask

    // Full pass with valid=ready=1: latency, write/shift/last-plane counts.
    task automatic run_pass(input string ph);
        int n_we, n_se, n_last, done_at;
        wait_idle(ph);
        n_we = 0; n_se = 0; n_last = 0; done_at = -1;
        step(1'b1, 1'b1, 1'b1, ph);
        for (int j = 1; j <= 60; j++) begin
            step(1'b0, 1'b1, 1'b1, ph);
            n_we   += s_we0;
            n_se   += s_se0;
            n_last += s_last0;
            if (s_done0 != 0) begin
                done_at = j;
                break;
            end
        end
        chk({ph, " done latency"}, 32'(done_at), 32'd28);
        chk({ph, " write count"}, 32'(n_we), 32'd4);
        chk({ph, " shift count"}, 32'(n_se), 32'd7);
        chk({ph, " last_bit cycles"}, 32'(n_last), 32'd2);
    endtask

    initial begin
        int reached;
        int n_we;
        int n_se;
        model_reset();
        rst_n = 1'b0;
        cur_v = 1'b0;
        bus0.i_start = 1'b0; bus0.i_in_valid = 1'b0; bus0.i_xbar_ready = 1'b0;
        bus1.i_start = 1'b0; bus1.i_in_valid = 1'b0; bus1.i_xbar_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, start ignored while in reset.
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b1, "reset");
        rst_n = 1'b1;

        // T1: clean pass, default timing.
        run_pass("T1");

        // T2: valid toggling during LOAD.
        wait_idle("T2");
        step(1'b1, 1'b0, 1'b1, "T2");
        n_we = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b0, (j % 2 == 0) ? 1'b1 : 1'b0, 1'b1, "T2");
            n_we += s_we0;
        end
        chk("T2 write count", 32'(n_we), 32'd4);
        wait_idle("T2");

        // T3: crossbar stalls on address 1 of plane 2.
        step(1'b1, 1'b1, 1'b1, "T3");
        reached = 0;
        for (int j = 0; j < 100; j++) begin
            if (is_stream(0) != 0 && m_k[0] == 5) begin
                reached = 1;
                break;
            end
            step(1'b0, 1'b1, 1'b1, "T3");
        end
        chk("T3 reached plane2 addr1", 32'(reached), 32'd1);
        n_se = 0;
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b1, 1'b0, "T3");
            chk("T3 held addr", 32'(s_addr0), 32'd1);
            chk("T3 held bit", 32'(s_bit0), 32'd2);
            n_se += s_se0;
        end
        chk("T3 no shift while stalled", 32'(n_se), 32'd0);
        step(1'b0, 1'b1, 1'b1, "T3");
        step(1'b0, 1'b1, 1'b1, "T3");
        chk("T3 shift after accept", 32'(s_se0), 32'd1);
        wait_idle("T3");

        // T5: asynchronous reset in the middle of plane 3.
        step(1'b1, 1'b1, 1'b1, "T5");
        reached = 0;
        for (int j = 0; j < 100; j++) begin
            if (is_stream(0) != 0 && m_k[0] / 2 == 3) begin
                reached = 1;
                break;
            end
            step(1'b0, 1'b1, 1'b1, "T5");
        end
        chk("T5 reached plane3", 32'(reached), 32'd1);
        chk("T5 streaming before reset", 32'(bus0.o_xbar_valid), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(0, "T5 async");
        check_all(1, "T5 async");
        @(posedge clk);
        #1;
        cyc++;
        step(1'b1, 1'b1, 1'b1, "T5 in reset");
        step(1'b0, 1'b1, 1'b1, "T5 in reset");
        rst_n = 1'b1;
        run_pass("T5 clean");

        // T6: start held high through STREAM and DONE; back-to-back passes.
        for (int j = 0; j < 70; j++) step(1'b1, 1'b1, 1'b1, "T6");
        wait_idle("T6");

        // Randomized traffic: sparse start, bursty valid and ready.
        for (int j = 0; j < 1500; j++) begin
            step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, "rand");
        end
        wait_idle("rand");

        // T4: the single-plane, single-address build never shifts yet completes passes.
        chk("T4 dut1 shift total", 32'(tot_se1), 32'd0);
        chk("T4 dut1 completed passes", 32'(tot_done1 > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
